// File: rtl/estu_inference_seq.sv
// -----------------------------------------------------------------------------
// estu_inference_seq
//   Sequences a complete ESTU inference over n_timesteps timesteps. Each
//   timestep runs the instruction stream up to last_instr. Every instruction
//   that uses or generates V first pulls a burst of ae_count address-events
//   from the external stack into the internal stack. abort returns to IDLE
//   from any state. All outputs are Moore, decoded from the state register.
//
//   Optional feature macro: ESTU_WDOG_EN
//     defined   -> watchdog on WAIT_INSTR / RUN; sets a sticky error and
//                  forces IDLE after WDOG_CYCLES cycles in either state
//     undefined -> no watchdog; error tied 0
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   start_inference            start request (IDLE only)
//   abort                      return to IDLE, highest priority
//   n_timesteps [TS_W]         timesteps per inference, latched at start (0 -> 1)
//   ae_count    [AE_W]         AE words per burst (0 -> 1)
//   use_v, v_gen_id            instruction needs / generates V
//   valid_instr                fetched instruction available
//   valid_op, last_instr       instruction complete / end of stream
//   valid_data                 mid-op request for a new AE burst
//   en, clr                    datapath enable / clear
//   fetch_instr                fetch request
//   r_en_ext_stack             external stack read enable
//   load_push_stack            push read word to internal stack
//   clr_pc                     program counter clear
//   valid_inference            one-cycle done pulse
//   busy                       high outside IDLE
//   timestep    [TS_W]         current timestep index
//   error                      sticky watchdog flag
// -----------------------------------------------------------------------------
module estu_inference_seq #(
  parameter int TS_W        = 8,
  parameter int AE_W        = 4,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_inference,
  input  logic            abort,
  input  logic [TS_W-1:0] n_timesteps,
  input  logic [AE_W-1:0] ae_count,
  input  logic            use_v,
  input  logic            v_gen_id,
  input  logic            valid_instr,
  input  logic            valid_op,
  input  logic            last_instr,
  input  logic            valid_data,
  output logic            en,
  output logic            clr,
  output logic            fetch_instr,
  output logic            r_en_ext_stack,
  output logic            load_push_stack,
  output logic            clr_pc,
  output logic            valid_inference,
  output logic            busy,
  output logic [TS_W-1:0] timestep,
  output logic            error
);

  typedef enum logic [3:0] {
    S_IDLE, S_CLR, S_FETCH, S_WAIT_INSTR, S_CHECK_V, S_READ_AE,
    S_LOAD_AE, S_SAVE_AE, S_RUN, S_NEXT_TS, S_DONE
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [TS_W-1:0] timestep_q;
  logic [TS_W-1:0] n_ts;
  logic [AE_W-1:0] ae_cnt;
  logic [AE_W-1:0] ae_load;
  logic            need_v;
  logic            last_ts;
  logic            wdog_trip;
  logic            error_q;

  assign need_v  = use_v | v_gen_id;
  // A zero burst length still moves one word.
  assign ae_load = (ae_count == '0) ? AE_W'(1) : ae_count;
  assign last_ts = (timestep_q == n_ts - TS_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      timestep_q <= '0;
      n_ts       <= TS_W'(1);
      ae_cnt     <= '0;
    end else begin
      state <= state_next;
      // abort freezes every register except state so timestep stays visible.
      if (!abort) begin
        case (state)
          S_IDLE: if (start_inference) begin
            n_ts       <= (n_timesteps == '0) ? TS_W'(1) : n_timesteps;
            timestep_q <= '0;
          end
          S_CHECK_V: if (need_v) ae_cnt <= ae_load;
          S_LOAD_AE: if (ae_cnt > AE_W'(1)) ae_cnt <= ae_cnt - AE_W'(1);
          S_RUN:     if (!valid_op && valid_data && need_v) ae_cnt <= ae_load;
          S_NEXT_TS: if (!last_ts) timestep_q <= timestep_q + TS_W'(1);
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    state_next      = state;
    en              = 1'b0;
    clr             = 1'b0;
    fetch_instr     = 1'b0;
    r_en_ext_stack  = 1'b0;
    load_push_stack = 1'b0;
    clr_pc          = 1'b0;
    valid_inference = 1'b0;
    busy            = (state != S_IDLE);

    if (abort || wdog_trip) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE:       if (start_inference) state_next = S_CLR;
        S_CLR:        state_next = S_FETCH;
        S_FETCH:      state_next = S_WAIT_INSTR;
        S_WAIT_INSTR: if (valid_instr) state_next = S_CHECK_V;
        S_CHECK_V:    state_next = need_v ? S_READ_AE : S_RUN;
        S_READ_AE:    state_next = S_LOAD_AE;
        S_LOAD_AE:    state_next = (ae_cnt > AE_W'(1)) ? S_READ_AE : S_SAVE_AE;
        S_SAVE_AE:    state_next = S_RUN;
        S_RUN: begin
          // Completion outranks a same-cycle burst request.
          if (valid_op)                  state_next = last_instr ? S_NEXT_TS : S_CLR;
          else if (valid_data && need_v) state_next = S_READ_AE;
        end
        S_NEXT_TS:    state_next = last_ts ? S_DONE : S_CLR;
        S_DONE:       state_next = S_IDLE;
        default:      state_next = S_IDLE;
      endcase
    end

    case (state)
      S_IDLE:    clr_pc          = 1'b1;
      S_CLR:     clr             = 1'b1;
      S_FETCH:   fetch_instr     = 1'b1;
      S_READ_AE: r_en_ext_stack  = 1'b1;
      S_LOAD_AE: load_push_stack = 1'b1;
      S_RUN:     en              = 1'b1;
      S_NEXT_TS: clr_pc          = 1'b1;
      S_DONE:    valid_inference = 1'b1;
      default: ;
    endcase
  end

`ifdef ESTU_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

  logic [WDOG_W-1:0] wdog_cnt;
  logic              wdog_state;

  assign wdog_state = (state == S_WAIT_INSTR) || (state == S_RUN);
  // Trips on the WDOG_CYCLES-th consecutive cycle spent in a waiting state.
  assign wdog_trip  = wdog_state && (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt <= '0;
      error_q  <= 1'b0;
    end else begin
      if (wdog_state && (state_next == state)) wdog_cnt <= wdog_cnt + WDOG_W'(1);
      else                                     wdog_cnt <= '0;
      if (!abort) begin
        if ((state == S_IDLE) && start_inference) error_q <= 1'b0;
        else if (wdog_trip)                       error_q <= 1'b1;
      end
    end
  end
`else
  // Always 0: the limit has no role without the watchdog.
  assign wdog_trip = (WDOG_CYCLES < 0);
  assign error_q   = 1'b0;
`endif

  assign timestep = timestep_q;
  assign error    = error_q;

endmodule
